// File: rtl/channel_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : channel_mixer
//  Purpose  : N-channel audio mixer. On each sample tick it snapshots the
//             channel samples, gains and mute mask, accumulates one channel
//             per clock, then emits one shifted and saturated output sample.
//  Option   : define CHANNEL_MIXER_PEAK_EN to build the peak-hold register
//             (o_peak / i_peak_clr); otherwise o_peak is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module channel_mixer #(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_WIDTH = 9,
  parameter int GAIN_WIDTH   = 4,
  parameter int OUT_WIDTH    = 8,
  parameter int OUT_SHIFT    = 4
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_sample_tick,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] i_samples,
  input  logic [NUM_CHANNELS*GAIN_WIDTH-1:0]   i_gain,
  input  logic [NUM_CHANNELS-1:0]            i_mute,
  input  logic                               i_peak_clr,
  output logic [OUT_WIDTH-1:0]               o_sample,
  output logic                               o_sample_valid,
  output logic                               o_busy,
  output logic                               o_overrun,
  output logic [OUT_WIDTH-1:0]               o_peak
);

  // Index is at least one bit wide so the single-channel build still works.
  localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int PROD_W = SAMPLE_WIDTH + GAIN_WIDTH;
  // One spare bit above the worst-case sum keeps the accumulator from wrapping.
  localparam int ACC_W  = PROD_W + $clog2(NUM_CHANNELS) + 1;
  localparam int unsigned OUT_MAX = (1 << OUT_WIDTH) - 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] OUTPUT = 2'd2;

  logic [1:0]                         state;
  logic [IDX_W-1:0]                   idx;
  logic [ACC_W-1:0]                   acc;
  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_snap;
  logic [NUM_CHANNELS*GAIN_WIDTH-1:0]   gain_snap;
  logic [NUM_CHANNELS-1:0]            mute_snap;
  logic [OUT_WIDTH-1:0]               sample_reg;
  logic                               valid_reg;
  logic                               overrun_reg;

  logic [SAMPLE_WIDTH-1:0] cur_sample;
  logic [GAIN_WIDTH-1:0]   cur_gain;
  logic [PROD_W-1:0]       product;
  logic [ACC_W-1:0]        acc_next;
  logic [ACC_W-1:0]        shifted;
  logic [OUT_WIDTH-1:0]    saturated;

  // Current channel term and the running sum including it; the final
  // channel's sum feeds the output directly so no extra cycle is needed.
  always_comb begin
    cur_sample = sample_snap[idx*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    cur_gain   = gain_snap[idx*GAIN_WIDTH +: GAIN_WIDTH];
    product    = PROD_W'(cur_sample) * PROD_W'(cur_gain);
    acc_next   = acc + (mute_snap[idx] ? '0 : ACC_W'(product));
    shifted    = acc_next >> OUT_SHIFT;
    saturated  = (shifted > ACC_W'(OUT_MAX)) ? {OUT_WIDTH{1'b1}}
                                             : shifted[OUT_WIDTH-1:0];
  end

  // Frame sequencer: snapshot on tick, accumulate one channel per clock,
  // publish the saturated result with a single-cycle valid pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      sample_snap <= '0;
      gain_snap   <= '0;
      mute_snap   <= '0;
      sample_reg  <= '0;
      valid_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_reg <= 1'b0;
          if (i_sample_tick) begin
            sample_snap <= i_samples;
            gain_snap   <= i_gain;
            mute_snap   <= i_mute;
            acc         <= '0;
            idx         <= '0;
            state       <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_next;
          if (idx == LAST_IDX) begin
            sample_reg <= saturated;
            valid_reg  <= 1'b1;
            state      <= OUTPUT;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        OUTPUT: begin
          valid_reg <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          valid_reg <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Sticky overrun: any tick that arrives while a frame is still running.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overrun_reg <= 1'b0;
    end else if (i_sample_tick && (state != IDLE)) begin
      overrun_reg <= 1'b1;
    end
  end

`ifdef CHANNEL_MIXER_PEAK_EN
  logic [OUT_WIDTH-1:0] peak_reg;

  // Peak hold: compare during the output cycle; a coincident clear restarts
  // tracking from the sample being published.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      peak_reg <= '0;
    end else if (state == OUTPUT) begin
      if (i_peak_clr || (sample_reg > peak_reg)) begin
        peak_reg <= sample_reg;
      end
    end else if (i_peak_clr) begin
      peak_reg <= '0;
    end
  end

  assign o_peak = peak_reg;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = i_peak_clr;
  assign o_peak          = '0;
`endif

  assign o_sample       = sample_reg;
  assign o_sample_valid = valid_reg;
  assign o_busy         = (state == ACCUM);
  assign o_overrun      = overrun_reg;

endmodule
`default_nettype wire

// File: tb/tb_channel_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_channel_mixer
//  Purpose  : Self-checking bench for channel_mixer: directed frames with
//             literal expectations plus randomized traffic against a
//             frame-timing reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_channel_mixer;

  localparam int N  = 4;
  localparam int SW = 9;
  localparam int GW = 4;
  localparam int OW = 8;
  localparam int SH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            tick;
  logic            peak_clr;
  logic [N*SW-1:0] samples;
  logic [N*GW-1:0] gain;
  logic [N-1:0]    mute;
  logic [OW-1:0]   o_sample;
  logic            o_valid;
  logic            o_busy;
  logic            o_overrun;
  logic [OW-1:0]   o_peak;

  channel_mixer #(
    .NUM_CHANNELS(N), .SAMPLE_WIDTH(SW), .GAIN_WIDTH(GW),
    .OUT_WIDTH(OW), .OUT_SHIFT(SH)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sample_tick(tick),
    .i_samples(samples), .i_gain(gain), .i_mute(mute),
    .i_peak_clr(peak_clr),
    .o_sample(o_sample), .o_sample_valid(o_valid), .o_busy(o_busy),
    .o_overrun(o_overrun), .o_peak(o_peak)
  );

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Reference model: a frame accepted in cycle t occupies cycles t+1..t+N+1
  // and publishes in cycle t+N+1.
  int t_start   = -100;
  int pend      = 0;
  int m_sample  = 0;
  int m_valid   = 0;
  int m_busy    = 0;
  int m_overrun = 0;
  int m_peak    = 0;

  function automatic int mix(input logic [N*SW-1:0] s, input logic [N*GW-1:0] g,
                             input logic [N-1:0] m);
    int sum = 0;
    for (int c = 0; c < N; c++)
      if (!m[c]) sum += int'(s[c*SW +: SW]) * int'(g[c*GW +: GW]);
    sum = sum >> SH;
    return (sum > (1 << OW) - 1) ? (1 << OW) - 1 : sum;
  endfunction

  function automatic int pk(input int v);
`ifdef CHANNEL_MIXER_PEAK_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic logic [N*SW-1:0] all_s(input int v);
    logic [N*SW-1:0] r;
    for (int c = 0; c < N; c++) r[c*SW +: SW] = SW'(v);
    return r;
  endfunction

  function automatic logic [N*GW-1:0] all_g(input int v);
    logic [N*GW-1:0] r;
    for (int c = 0; c < N; c++) r[c*GW +: GW] = GW'(v);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Advance the model with the inputs of cycle k, giving expectations for k+1.
  task automatic model_step();
    int k = cyc;
    if (rst) begin
      t_start = -100; m_sample = 0; m_overrun = 0; m_peak = 0;
    end else begin
`ifdef CHANNEL_MIXER_PEAK_EN
      if (k == t_start + N + 1) m_peak = peak_clr ? m_sample : (m_sample > m_peak ? m_sample : m_peak);
      else if (peak_clr) m_peak = 0;
`endif
      if (tick) begin
        if (k >= t_start + 1 && k <= t_start + N + 1) m_overrun = 1;
        else begin
          t_start = k;
          pend    = mix(samples, gain, mute);
        end
      end
    end
    m_busy  = (k + 1 >= t_start + 1 && k + 1 <= t_start + N) ? 1 : 0;
    m_valid = (k + 1 == t_start + N + 1) ? 1 : 0;
    if (m_valid != 0) m_sample = pend;
  endtask

  // One clock: update model, then compare every output one step after the edge.
  task automatic step();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    chk("model_sample",  int'(o_sample),  m_sample);
    chk("model_valid",   int'(o_valid),   m_valid);
    chk("model_busy",    int'(o_busy),    m_busy);
    chk("model_overrun", int'(o_overrun), m_overrun);
    chk("model_peak",    int'(o_peak),    m_peak);
  endtask

  task automatic set_in(input logic [N*SW-1:0] s, input logic [N*GW-1:0] g,
                        input logic [N-1:0] m);
    samples = s; gain = g; mute = m;
  endtask

  // Directed frame with literal expectations on timing, value and peak.
  task automatic frame(input logic [N*SW-1:0] s, input logic [N*GW-1:0] g,
                       input logic [N-1:0] m, input int exp_s, input int exp_p);
    set_in(s, g, m);
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int i = 1; i <= N + 2; i++) begin
      chk("frame_busy",  int'(o_busy),  (i <= N) ? 1 : 0);
      chk("frame_valid", int'(o_valid), (i == N + 1) ? 1 : 0);
      if (i == N + 1) chk("frame_sample", int'(o_sample), exp_s);
      if (i == N + 2) chk("frame_peak", int'(o_peak), exp_p);
      step();
    end
  endtask

  initial begin
    int vcount;
    rst = 1'b1; tick = 1'b0; peak_clr = 1'b0;
    set_in('0, '0, '0);
    step();
    chk("reset_sample",  int'(o_sample),  0);
    chk("reset_valid",   int'(o_valid),   0);
    chk("reset_busy",    int'(o_busy),    0);
    chk("reset_overrun", int'(o_overrun), 0);
    chk("reset_peak",    int'(o_peak),    0);
    step();
    rst = 1'b0;
    while (cyc < 10) step();

    // Tick in cycle 10: busy 11..14, valid in 15 with 400>>4.
    frame(all_s(100), all_g(1), 4'b0000, 25, pk(25));
    frame(all_s(100), all_g(1), 4'b1010, 12, pk(25));
    frame(all_s(511), all_g(15), 4'b0000, 255, pk(255));

    // Second tick two cycles in: ignored, overrun, snapshot protects frame.
    begin
      int t0;
      chk("pre_overrun", int'(o_overrun), 0);
      set_in(all_s(100), all_g(1), 4'b0000);
      tick = 1'b1; t0 = cyc; step(); tick = 1'b0;
      step();
      set_in(all_s(511), all_g(15), 4'b0000);
      tick = 1'b1; step(); tick = 1'b0;
      chk("overrun_set", int'(o_overrun), 1);
      vcount = 0;
      while (cyc < t0 + 10) begin
        if (o_valid) begin
          vcount++;
          chk("overrun_valid_cycle", cyc, t0 + N + 1);
          chk("overrun_sample", int'(o_sample), 25);
        end
        step();
      end
      chk("overrun_one_valid", vcount, 1);
      chk("overrun_sticky", int'(o_overrun), 1);
    end

    // Reset mid-frame aborts it; outputs clear; next frame works.
    set_in(all_s(100), all_g(1), 4'b0000);
    tick = 1'b1; step(); tick = 1'b0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_valid) vcount++;
      step();
    end
    chk("abort_no_valid", vcount, 0);
    chk("abort_sample",   int'(o_sample),  0);
    chk("abort_overrun",  int'(o_overrun), 0);
    chk("abort_busy",     int'(o_busy),    0);
    frame(all_s(100), all_g(1), 4'b0000, 25, pk(25));
    frame(all_s(511), all_g(15), 4'b0000, 255, pk(255));
    frame(all_s(100), all_g(1), 4'b1010, 12, pk(255));
    peak_clr = 1'b1; step(); peak_clr = 1'b0;
    chk("peak_cleared", int'(o_peak), 0);
    frame(all_s(100), all_g(1), 4'b1010, 12, pk(12));
    frame(all_s(300), all_g(0), 4'b0000, 0, pk(12));
    frame(all_s(300), all_g(9), 4'b1111, 0, pk(12));

    // Randomized traffic: model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        samples[c*SW +: SW] = SW'($urandom_range(0, (1 << SW) - 1));
        gain[c*GW +: GW]    = GW'($urandom_range(0, (1 << GW) - 1));
      end
      mute     = N'($urandom_range(0, (1 << N) - 1));
      tick     = ($urandom_range(0, 3) == 0);
      peak_clr = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 1'b0; tick = 1'b0; peak_clr = 1'b0;
    repeat (N + 3) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
